gemm_mem_arbiter: RTL and testbench
===================================

Name: gemm_mem_arbiter

Overview:
- Arbitrates the single shared 128-bit-wide data memory between the GEMM accelerator's memory interface and the RISC-V core's 32-bit data port.
- The GEMM side has no back-pressure and assumes fixed 1-cycle read latency, so it always wins. The core is stalled on conflict.
- Sits directly downstream of the gemm top: it consumes interface_en/rdwr/addr/control/wr_data and returns interface_rd_data.

Parameters:
- LINE_AW, 12, memory line-address width (4096 x 128-bit lines = 64 KiB).
- BASE_ADDR, 32'h0001_0000, byte base address of the data memory in the system map.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- interface_en  in  1  GEMM access request this cycle
- interface_rdwr  in  1  1 = write, 0 = read
- interface_addr  in  32  GEMM byte address, 16-byte aligned
- interface_control  in  5  [3:0] write lane enables (lane i = bits 32i+31:32i); [4] reserved, ignored
- interface_wr_data  in  4x32  GEMM write lanes
- interface_rd_data  out  128  GEMM read line
- cpu_req  in  1  core load/store request, held while cpu_stall is high
- cpu_we  in  1  1 = store
- cpu_addr  in  32  core byte address, word aligned
- cpu_wdata  in  32  store data
- cpu_be  in  4  store byte enables
- cpu_rdata  out  32  load data
- cpu_stall  out  1  core must hold its request
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  LINE_AW  line address
- mem_wmask  out  16  byte write mask
- mem_wdata  out  128  write line
- mem_rdata  in  128  read data, valid the cycle after mem_en & !mem_we
- conflict_cnt  out  32  saturating count of cycles the core was stalled by GEMM
- addr_err  out  1  sticky: an access fell outside [BASE_ADDR, BASE_ADDR + 16*2^LINE_AW)

Behaviour:
- Line address: line = (addr - BASE_ADDR) >> 4, truncated to LINE_AW bits. Core lane = cpu_addr[3:2].
- FSM states:
  - IDLE to RD_WAIT: on a core read issued to memory.
  - RD_WAIT to IDLE: unconditionally after one cycle.
- Priority: interface_en always drives the memory port in any state.
- GEMM read: mem_en=1, mem_we=0. interface_rd_data = mem_rdata combinationally; valid exactly 1 cycle after interface_en.
- GEMM write: mem_wmask[4i+3:4i] = {4{interface_control[i]}}; mem_wdata = interface_wr_data packed with lane 0 in the LSBs.
- Core access in IDLE:
  - If interface_en=1: cpu_stall=1, nothing issued, conflict_cnt increments (saturates at 32'hFFFF_FFFF).
  - Otherwise, store: issue mem_we=1, mem_wmask = cpu_be shifted to the lane, wdata replicated to all lanes, cpu_stall=0. Completes in the same cycle.
  - Otherwise, load: issue the read, cpu_stall=1, latch the lane, go to RD_WAIT.
- RD_WAIT:
  - cpu_rdata = latched lane of mem_rdata; cpu_stall=0 so the core consumes it.
  - cpu_req is not re-arbitrated (it is the completing request). Next state is IDLE.
  - The port is free for GEMM this cycle; a GEMM read issued here returns next cycle.
- cpu_rdata holds its last value in other states.
- The memory port is never driven by both masters in one cycle. mem_en=0 when neither master issues.
- addr_err:
  - Set on any issued access out of range. That access is suppressed: mem_en=0, GEMM sees read data 0, core store is dropped and core load returns 0.
  - Cleared only by rst.
- Reset (including mid-read): state=IDLE, cpu_stall=0, cpu_rdata=0, conflict_cnt=0, addr_err=0, lane latch=0. An in-flight read result is discarded.
- Memory outputs are combinational from current inputs/state. No added latency on the GEMM path.

Decomposition:
- Shared package (Config): LINE_AW default, BASE_ADDR, and the arb_state_t enum {IDLE, RD_WAIT}.
- Lane/byte-mask expansion is a natural sub-module: lane_mask_expand (4-bit lane or byte enables plus lane index in, 16-bit mask out).
- Everything else stays inline.

Test Plan:
- GEMM read at 32'h0001_0020 with memory preloaded: mem_addr=2 that cycle, interface_rd_data equals line 2 one cycle later; core idle and unaffected.
- Core load at 32'h0001_0034 with no GEMM activity: cpu_stall=1 for 1 cycle, then cpu_rdata equals lane 1 of line 3 and cpu_stall=0.
- Core store 32'hDEAD_BEEF to 32'h0001_0008 with be=4'b0011: mem_wmask=16'h0300, no stall; a readback gives lane 2 low half = 16'hBEEF.
- Core load held while GEMM streams 5 back-to-back reads: cpu_stall=1 for those 5 cycles, conflict_cnt=5, then the load completes in 2 more cycles.
- GEMM write with control=5'b0_0101: only bytes 0-3 and 8-11 change; a core load issued in the same cycle stalls one cycle.
- Access to 32'h0000_FFF0: addr_err=1, mem_en=0, core load returns 0; rst asserted mid-RD_WAIT: cpu_stall=0, addr_err=0, FSM in IDLE next cycle.

Source files
------------

// File: rtl/gemm_mem_arbiter_pkg.sv
// Shared configuration for the GEMM / core data-memory arbiter.
//   LINE_AW_DEF   : default memory line-address width (4096 x 128-bit lines)
//   BASE_ADDR_DEF : byte base address of the data memory in the system map
//   arb_state_t   : arbiter FSM states
//   addr_in_range : window check for a byte address against the memory window
package gemm_mem_arbiter_pkg;

  localparam int unsigned LINE_AW_DEF   = 12;
  localparam logic [31:0] BASE_ADDR_DEF = 32'h0001_0000;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

  // True when addr lies in [base, base + 16 * 2^line_aw). Done in 33 bits so a
  // window ending exactly at 4 GiB does not wrap.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned line_aw);
    logic [32:0] lo;
    logic [32:0] hi;
    lo = {1'b0, base};
    hi = lo + (33'd16 << line_aw);
    return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
  endfunction

endpackage

// File: rtl/gemm_mem_arbiter_if.sv
// Bundle of the three buses around the arbiter: GEMM memory interface, core
// data port and the shared memory port.
//   slave  : the arbiter's view (takes requests, drives memory and responses)
//   master : the environment's view (GEMM, core and memory models)
interface gemm_mem_arbiter_if #(
  parameter int unsigned LINE_AW = gemm_mem_arbiter_pkg::LINE_AW_DEF
) ();

  // GEMM side
  logic              interface_en;
  logic              interface_rdwr;      // 1 = write
  logic [31:0]       interface_addr;      // 16-byte aligned
  logic [4:0]        interface_control;   // [3:0] lane write enables
  logic [3:0][31:0]  interface_wr_data;   // lane 0 in the LSBs
  logic [127:0]      interface_rd_data;

  // Core side
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_be;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;

  // Shared memory port
  logic              mem_en;
  logic              mem_we;
  logic [LINE_AW-1:0] mem_addr;
  logic [15:0]       mem_wmask;
  logic [127:0]      mem_wdata;
  logic [127:0]      mem_rdata;

  modport slave (
    input  interface_en, interface_rdwr, interface_addr, interface_control,
           interface_wr_data,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  mem_rdata,
    output interface_rd_data, cpu_rdata, cpu_stall,
    output mem_en, mem_we, mem_addr, mem_wmask, mem_wdata
  );

  modport master (
    output interface_en, interface_rdwr, interface_addr, interface_control,
           interface_wr_data,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output mem_rdata,
    input  interface_rd_data, cpu_rdata, cpu_stall,
    input  mem_en, mem_we, mem_addr, mem_wmask, mem_wdata
  );

endinterface

// File: rtl/gemm_mem_arbiter_mask.sv
// Expands 4 enable bits into a 16-bit byte mask for a 128-bit line.
//   lane_mode_i = 1 : en_i are lane enables, each covers 4 bytes (lane_i ignored)
//   lane_mode_i = 0 : en_i are byte enables placed in lane lane_i
//   mask_o          : byte write mask, bit b covers line byte b
module lane_mask_expand (
  input  logic        lane_mode_i,
  input  logic [3:0]  en_i,
  input  logic [1:0]  lane_i,
  output logic [15:0] mask_o
);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    mask_o = '0;
    if (lane_mode_i) begin
      for (int i = 0; i < 4; i++) begin
        mask_o[4*i +: 4] = {4{en_i[i]}};
      end
    end else begin
      mask_o = {12'd0, en_i} << {lane_i, 2'b00};
    end
  end

endmodule

// File: rtl/gemm_mem_arbiter.sv
// Arbiter for the single 128-bit data memory shared by the GEMM accelerator
// and the core's 32-bit data port. GEMM has fixed 1-cycle read latency and no
// back-pressure, so it always wins; the core is stalled on conflict.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : GEMM, core and memory buses (slave view)
//   conflict_cnt : saturating count of core cycles stalled by GEMM
//   addr_err     : sticky flag, some access fell outside the memory window
module gemm_mem_arbiter
  import gemm_mem_arbiter_pkg::*;
#(
  parameter int unsigned LINE_AW   = LINE_AW_DEF,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic                clk,
  input  logic                rst,
  gemm_mem_arbiter_if.slave   bus,
  output logic [31:0]         conflict_cnt,
  output logic                addr_err
);

  arb_state_t         state_q, state_d;
  logic [1:0]         lane_q, lane_d;          // lane of the pending core load
  logic               cpu_zero_q, cpu_zero_d;  // pending core load was suppressed
  logic               gemm_zero_q;             // last-cycle GEMM read was suppressed
  logic [31:0]        conflict_cnt_q;
  logic [31:0]        cpu_rdata_q;
  logic               addr_err_q;

  logic               conflict_inc;
  logic               err_set;

  logic               gemm_ok, cpu_ok;
  logic [LINE_AW-1:0] gemm_line, cpu_line;
  logic [15:0]        gemm_mask, cpu_mask;
  logic [31:0]        rd_lane;

  logic               mem_en, mem_we;
  logic [LINE_AW-1:0] mem_addr;
  logic [15:0]        mem_wmask;
  logic [127:0]       mem_wdata;

  // Control bit 4 is reserved and has no effect.
  logic               unused_ctrl;
  assign unused_ctrl = bus.interface_control[4];

  assign gemm_ok   = addr_in_range(bus.interface_addr, BASE_ADDR, LINE_AW);
  assign cpu_ok    = addr_in_range(bus.cpu_addr, BASE_ADDR, LINE_AW);
  assign gemm_line = LINE_AW'((bus.interface_addr - BASE_ADDR) >> 4);
  assign cpu_line  = LINE_AW'((bus.cpu_addr - BASE_ADDR) >> 4);

  lane_mask_expand u_gemm_mask (
    .lane_mode_i (1'b1),
    .en_i        (bus.interface_control[3:0]),
    .lane_i      (2'b00),
    .mask_o      (gemm_mask)
  );

  lane_mask_expand u_cpu_mask (
    .lane_mode_i (1'b0),
    .en_i        (bus.cpu_be),
    .lane_i      (bus.cpu_addr[3:2]),
    .mask_o      (cpu_mask)
  );

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    cpu_zero_d   = cpu_zero_q;
    conflict_inc = 1'b0;
    err_set      = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wmask    = '0;
    mem_wdata    = '0;

    // GEMM owns the port whenever it asks, whatever the FSM state.
    if (bus.interface_en) begin
      if (gemm_ok) begin
        mem_en   = 1'b1;
        mem_we   = bus.interface_rdwr;
        mem_addr = gemm_line;
        if (bus.interface_rdwr) begin
          mem_wmask = gemm_mask;
          mem_wdata = bus.interface_wr_data;
        end
      end else begin
        err_set = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          if (bus.interface_en) begin
            conflict_inc = 1'b1;
          end else if (bus.cpu_we) begin
            if (cpu_ok) begin
              mem_en    = 1'b1;
              mem_we    = 1'b1;
              mem_addr  = cpu_line;
              mem_wmask = cpu_mask;
              mem_wdata = {4{bus.cpu_wdata}};
            end else begin
              err_set = 1'b1;
            end
          end else begin
            // Load: an out-of-range load still takes the RD_WAIT cycle so the
            // core sees the same timing, but returns 0.
            state_d    = RD_WAIT;
            lane_d     = bus.cpu_addr[3:2];
            cpu_zero_d = !cpu_ok;
            if (cpu_ok) begin
              mem_en   = 1'b1;
              mem_addr = cpu_line;
            end else begin
              err_set = 1'b1;
            end
          end
        end
      end
      RD_WAIT: begin
        // The held request is the one completing now; it is not re-arbitrated.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The core stalls in IDLE on a conflict or while its load is in flight; a
  // store completes immediately.
  assign bus.cpu_stall = (state_q == IDLE) && bus.cpu_req &&
                         (bus.interface_en || !bus.cpu_we);

  assign rd_lane = cpu_zero_q ? 32'd0 : bus.mem_rdata[32*lane_q +: 32];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      lane_q         <= 2'd0;
      cpu_zero_q     <= 1'b0;
      gemm_zero_q    <= 1'b0;
      conflict_cnt_q <= 32'd0;
      cpu_rdata_q    <= 32'd0;
      addr_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      cpu_zero_q  <= cpu_zero_d;
      gemm_zero_q <= bus.interface_en && !bus.interface_rdwr && !gemm_ok;
      if (conflict_inc && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
        conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
      if (state_q == RD_WAIT) begin
        cpu_rdata_q <= rd_lane;
      end
      if (err_set) begin
        addr_err_q <= 1'b1;
      end
    end
  end

  assign bus.cpu_rdata         = (state_q == RD_WAIT) ? rd_lane : cpu_rdata_q;
  assign bus.interface_rd_data = gemm_zero_q ? 128'd0 : bus.mem_rdata;

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wmask = mem_wmask;
  assign bus.mem_wdata = mem_wdata;

  assign conflict_cnt = conflict_cnt_q;
  assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_gemm_mem_arbiter.sv
module tb_gemm_mem_arbiter;
  import gemm_mem_arbiter_pkg::*;

  localparam int unsigned AW   = 12;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] conflict_cnt;
  logic        addr_err;

  int          total = 0;
  int          bad   = 0;
  int unsigned exp_cnt = 0;

  logic [127:0] mem     [4096];  // storage behind the memory port
  logic [127:0] ref_mem [4096];  // expected memory contents

  gemm_mem_arbiter_if #(.LINE_AW(AW)) bus ();

  gemm_mem_arbiter #(.LINE_AW(AW), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .conflict_cnt (conflict_cnt),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  // Synchronous memory: 1-cycle read latency, byte-masked writes.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 16; b++)
          if (bus.mem_wmask[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= mem[bus.mem_addr];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] addr_of(input logic [AW-1:0] line, input logic [1:0] lane);
    return BASE + {16'd0, line, 4'd0} + {28'd0, lane, 2'd0};
  endfunction

  function automatic logic [15:0] lanes_to_mask(input logic [3:0] en);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (en[i]) m[4*i +: 4] = 4'hF;
    return m;
  endfunction

  function automatic void ref_write(input logic [AW-1:0] line, input logic [15:0] mask,
                                    input logic [127:0] data);
    for (int b = 0; b < 16; b++)
      if (mask[b]) ref_mem[line][8*b +: 8] = data[8*b +: 8];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.interface_en      = 1'b0;
    bus.interface_rdwr    = 1'b0;
    bus.interface_addr    = '0;
    bus.interface_control = '0;
    bus.interface_wr_data = '0;
    bus.cpu_req           = 1'b0;
    bus.cpu_we            = 1'b0;
    bus.cpu_addr          = '0;
    bus.cpu_wdata         = '0;
    bus.cpu_be            = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bus.cpu_stall); end
    total++; if (bus.cpu_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", bus.cpu_rdata); end
    total++; if (conflict_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", conflict_cnt); end
    total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", addr_err); end
    total++; if (bus.mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en: got %b want 0", bus.mem_en); end
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  // Streams GEMM reads back to back; first one is the line-2 case.
  task automatic test_gemm_read();
    logic [AW-1:0] line, prev;
    prev = '0;
    for (int i = 0; i < 8; i++) begin
      line = (i == 0) ? AW'(2) : AW'($urandom);
      cyc();
      if (i > 0) begin
        total++; if (bus.interface_rd_data !== ref_mem[prev]) begin bad++; $display("FAIL gemm_rd_data line %0d: got %h want %h", prev, bus.interface_rd_data, ref_mem[prev]); end
      end
      bus.interface_en   = 1'b1;
      bus.interface_rdwr = 1'b0;
      bus.interface_addr = addr_of(line, 2'd0);
      #1;
      total++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL gemm_rd_strobe: got en=%b we=%b want en=1 we=0", bus.mem_en, bus.mem_we); end
      total++; if (bus.mem_addr !== line) begin bad++; $display("FAIL gemm_rd_addr: got %0d want %0d", bus.mem_addr, line); end
      total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL gemm_rd_core_stall: got %b want 0", bus.cpu_stall); end
      prev = line;
    end
    cyc();
    total++; if (bus.interface_rd_data !== ref_mem[prev]) begin bad++; $display("FAIL gemm_rd_last line %0d: got %h want %h", prev, bus.interface_rd_data, ref_mem[prev]); end
    clear_inputs();
  endtask

  task automatic test_core_load();
    logic [AW-1:0] line;
    logic [1:0]    lane;
    logic [31:0]   want;
    for (int i = 0; i < 6; i++) begin
      line = (i == 0) ? AW'(3) : AW'($urandom);
      lane = (i == 0) ? 2'd1 : 2'($urandom);
      want = ref_mem[line][32*lane +: 32];
      cyc();
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = addr_of(line, lane);
      #1;
      total++; if (bus.cpu_stall !== 1'b1) begin bad++; $display("FAIL load_issue_stall: got %b want 1", bus.cpu_stall); end
      total++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== line) begin bad++; $display("FAIL load_issue: got en=%b we=%b addr=%0d want 1 0 %0d", bus.mem_en, bus.mem_we, bus.mem_addr, line); end
      cyc();
      total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL load_done_stall: got %b want 0", bus.cpu_stall); end
      total++; if (bus.cpu_rdata !== want) begin bad++; $display("FAIL load_data: got %h want %h", bus.cpu_rdata, want); end
      bus.cpu_req = 1'b0;
      cyc();
      total++; if (bus.cpu_rdata !== want) begin bad++; $display("FAIL load_hold: got %h want %h", bus.cpu_rdata, want); end
    end
    clear_inputs();
  endtask

  task automatic test_core_store();
    logic [AW-1:0] line;
    logic [1:0]    lane;
    logic [3:0]    be;
    logic [31:0]   data, want;
    logic [15:0]   mask;
    for (int i = 0; i < 6; i++) begin
      line = (i == 0) ? AW'(0) : AW'($urandom);
      lane = (i == 0) ? 2'd2 : 2'($urandom);
      be   = (i == 0) ? 4'b0011 : 4'($urandom);
      data = (i == 0) ? 32'hDEAD_BEEF : $urandom;
      mask = 16'(be) << (4 * lane);
      cyc();
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = addr_of(line, lane);
      bus.cpu_wdata = data;
      bus.cpu_be    = be;
      #1;
      if (i == 0) begin
        total++; if (bus.mem_wmask !== 16'h0300) begin bad++; $display("FAIL store_mask_fixed: got %h want 0300", bus.mem_wmask); end
      end
      total++; if (bus.mem_wmask !== mask || bus.mem_addr !== line) begin bad++; $display("FAIL store_mask: got %h @%0d want %h @%0d", bus.mem_wmask, bus.mem_addr, mask, line); end
      total++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL store_strobe: got en=%b we=%b stall=%b want 1 1 0", bus.mem_en, bus.mem_we, bus.cpu_stall); end
      total++; if (bus.mem_wdata !== {4{data}}) begin bad++; $display("FAIL store_wdata: got %h want %h", bus.mem_wdata, {4{data}}); end
      ref_write(line, mask, {4{data}});
      cyc();
      bus.cpu_we = 1'b0;
      want = ref_mem[line][32*lane +: 32];
      cyc();
      cyc();
      total++; if (bus.cpu_rdata !== want) begin bad++; $display("FAIL store_readback: got %h want %h", bus.cpu_rdata, want); end
      if (i == 0) begin
        total++; if (bus.cpu_rdata[15:0] !== 16'hBEEF) begin bad++; $display("FAIL store_beef: got %h want beef", bus.cpu_rdata[15:0]); end
      end
      clear_inputs();
    end
  endtask

  // Core load held while GEMM streams 5 reads.
  task automatic test_back_to_back();
    logic [AW-1:0] g [5];
    logic [AW-1:0] c;
    logic [1:0]    lane;
    c    = AW'($urandom);
    lane = 2'($urandom);
    for (int k = 0; k < 5; k++) g[k] = AW'($urandom);
    cyc();
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = addr_of(c, lane);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        cyc();
        total++; if (bus.interface_rd_data !== ref_mem[g[k-1]]) begin bad++; $display("FAIL b2b_gemm_data %0d: got %h want %h", k-1, bus.interface_rd_data, ref_mem[g[k-1]]); end
      end
      bus.interface_en   = 1'b1;
      bus.interface_rdwr = 1'b0;
      bus.interface_addr = addr_of(g[k], 2'd0);
      #1;
      total++; if (bus.cpu_stall !== 1'b1 || bus.mem_addr !== g[k]) begin bad++; $display("FAIL b2b_conflict %0d: got stall=%b addr=%0d want 1 %0d", k, bus.cpu_stall, bus.mem_addr, g[k]); end
      exp_cnt++;
    end
    cyc();
    total++; if (bus.interface_rd_data !== ref_mem[g[4]]) begin bad++; $display("FAIL b2b_gemm_last: got %h want %h", bus.interface_rd_data, ref_mem[g[4]]); end
    bus.interface_en = 1'b0;
    #1;
    total++; if (bus.cpu_stall !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_addr !== c) begin bad++; $display("FAIL b2b_load_issue: got stall=%b en=%b addr=%0d want 1 1 %0d", bus.cpu_stall, bus.mem_en, bus.mem_addr, c); end
    total++; if (conflict_cnt !== exp_cnt) begin bad++; $display("FAIL b2b_conflict_cnt: got %0d want %0d", conflict_cnt, exp_cnt); end
    cyc();
    total++; if (bus.cpu_stall !== 1'b0 || bus.cpu_rdata !== ref_mem[c][32*lane +: 32]) begin bad++; $display("FAIL b2b_load_done: got stall=%b data=%h want 0 %h", bus.cpu_stall, bus.cpu_rdata, ref_mem[c][32*lane +: 32]); end
    clear_inputs();
  endtask

  // GEMM write with a core load arriving in the same cycle.
  task automatic test_gemm_write();
    logic [AW-1:0]    line;
    logic [1:0]       lane;
    logic [4:0]       ctrl;
    logic [3:0][31:0] wd;
    logic [15:0]      mask;
    for (int i = 0; i < 4; i++) begin
      line = AW'($urandom);
      lane = 2'($urandom);
      ctrl = (i == 0) ? 5'b0_0101 : 5'($urandom);
      for (int l = 0; l < 4; l++) wd[l] = $urandom;
      mask = lanes_to_mask(ctrl[3:0]);
      cyc();
      bus.interface_en      = 1'b1;
      bus.interface_rdwr    = 1'b1;
      bus.interface_addr    = addr_of(line, 2'd0);
      bus.interface_control = ctrl;
      bus.interface_wr_data = wd;
      bus.cpu_req           = 1'b1;
      bus.cpu_we            = 1'b0;
      bus.cpu_addr          = addr_of(line, lane);
      #1;
      if (i == 0) begin
        total++; if (bus.mem_wmask !== 16'h0F0F) begin bad++; $display("FAIL gwr_mask_fixed: got %h want 0f0f", bus.mem_wmask); end
      end
      total++; if (bus.mem_wmask !== mask || bus.mem_we !== 1'b1 || bus.mem_addr !== line) begin bad++; $display("FAIL gwr_port: got mask=%h we=%b addr=%0d want %h 1 %0d", bus.mem_wmask, bus.mem_we, bus.mem_addr, mask, line); end
      total++; if (bus.mem_wdata !== 128'(wd)) begin bad++; $display("FAIL gwr_wdata: got %h want %h", bus.mem_wdata, 128'(wd)); end
      total++; if (bus.cpu_stall !== 1'b1) begin bad++; $display("FAIL gwr_core_stall: got %b want 1", bus.cpu_stall); end
      ref_write(line, mask, 128'(wd));
      exp_cnt++;
      cyc();
      bus.interface_en = 1'b0;
      #1;
      total++; if (bus.cpu_stall !== 1'b1 || bus.mem_addr !== line || bus.mem_we !== 1'b0) begin bad++; $display("FAIL gwr_load_issue: got stall=%b addr=%0d we=%b want 1 %0d 0", bus.cpu_stall, bus.mem_addr, bus.mem_we, line); end
      cyc();
      total++; if (bus.cpu_rdata !== ref_mem[line][32*lane +: 32]) begin bad++; $display("FAIL gwr_load_data: got %h want %h", bus.cpu_rdata, ref_mem[line][32*lane +: 32]); end
      clear_inputs();
      cyc();
      bus.interface_en   = 1'b1;
      bus.interface_addr = addr_of(line, 2'd0);
      cyc();
      total++; if (bus.interface_rd_data !== ref_mem[line]) begin bad++; $display("FAIL gwr_readback: got %h want %h", bus.interface_rd_data, ref_mem[line]); end
      clear_inputs();
    end
    total++; if (conflict_cnt !== exp_cnt) begin bad++; $display("FAIL gwr_conflict_cnt: got %0d want %0d", conflict_cnt, exp_cnt); end
  endtask

  // Random sequence of single operations checked against the reference memory.
  task automatic test_random_mix();
    logic [AW-1:0]    line;
    logic [1:0]       lane;
    logic [3:0][31:0] wd;
    logic [4:0]       ctrl;
    logic [3:0]       be;
    int unsigned      op;
    for (int n = 0; n < 24; n++) begin
      op   = $urandom_range(0, 3);
      line = AW'($urandom);
      lane = 2'($urandom);
      for (int l = 0; l < 4; l++) wd[l] = $urandom;
      ctrl = 5'($urandom);
      be   = 4'($urandom);
      cyc();
      case (op)
        0: begin
          bus.interface_en   = 1'b1;
          bus.interface_addr = addr_of(line, 2'd0);
          cyc();
          total++; if (bus.interface_rd_data !== ref_mem[line]) begin bad++; $display("FAIL mix_gemm_rd: got %h want %h", bus.interface_rd_data, ref_mem[line]); end
        end
        1: begin
          bus.interface_en      = 1'b1;
          bus.interface_rdwr    = 1'b1;
          bus.interface_addr    = addr_of(line, 2'd0);
          bus.interface_control = ctrl;
          bus.interface_wr_data = wd;
          ref_write(line, lanes_to_mask(ctrl[3:0]), 128'(wd));
          cyc();
        end
        2: begin
          bus.cpu_req  = 1'b1;
          bus.cpu_addr = addr_of(line, lane);
          cyc();
          total++; if (bus.cpu_rdata !== ref_mem[line][32*lane +: 32] || bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL mix_core_ld: got %h stall=%b want %h 0", bus.cpu_rdata, bus.cpu_stall, ref_mem[line][32*lane +: 32]); end
        end
        default: begin
          bus.cpu_req   = 1'b1;
          bus.cpu_we    = 1'b1;
          bus.cpu_addr  = addr_of(line, lane);
          bus.cpu_wdata = wd[0];
          bus.cpu_be    = be;
          ref_write(line, 16'(be) << (4 * lane), {4{wd[0]}});
          cyc();
        end
      endcase
      clear_inputs();
    end
  endtask

  task automatic test_addr_err();
    logic [AW-1:0] line;
    // Last line of the window is legal.
    cyc();
    bus.interface_en   = 1'b1;
    bus.interface_addr = 32'h0001_FFF0;
    #1;
    total++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== AW'(4095)) begin bad++; $display("FAIL err_top_line: got en=%b addr=%0d want 1 4095", bus.mem_en, bus.mem_addr); end
    cyc();
    total++; if (addr_err !== 1'b0 || bus.interface_rd_data !== ref_mem[4095]) begin bad++; $display("FAIL err_top_line_data: got err=%b data=%h want 0 %h", addr_err, bus.interface_rd_data, ref_mem[4095]); end
    clear_inputs();
    // Core load just below the window.
    cyc();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0000_FFF0;
    #1;
    total++; if (bus.mem_en !== 1'b0 || bus.cpu_stall !== 1'b1) begin bad++; $display("FAIL err_load_issue: got en=%b stall=%b want 0 1", bus.mem_en, bus.cpu_stall); end
    cyc();
    total++; if (bus.cpu_rdata !== 32'd0 || bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL err_load_data: got %h stall=%b want 0 0", bus.cpu_rdata, bus.cpu_stall); end
    total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL err_flag: got %b want 1", addr_err); end
    clear_inputs();
    // GEMM read just past the window.
    cyc();
    bus.interface_en   = 1'b1;
    bus.interface_addr = 32'h0002_0000;
    #1;
    total++; if (bus.mem_en !== 1'b0) begin bad++; $display("FAIL err_gemm_en: got %b want 0", bus.mem_en); end
    cyc();
    total++; if (bus.interface_rd_data !== 128'd0) begin bad++; $display("FAIL err_gemm_data: got %h want 0", bus.interface_rd_data); end
    clear_inputs();
    // Out-of-range store is dropped.
    cyc();
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b1;
    bus.cpu_be   = 4'hF;
    bus.cpu_addr = 32'h0002_0004;
    #1;
    total++; if (bus.mem_en !== 1'b0 || bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL err_store: got en=%b stall=%b want 0 0", bus.mem_en, bus.cpu_stall); end
    clear_inputs();
    // Reset while a load sits in RD_WAIT.
    line = AW'($urandom);
    cyc();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = addr_of(line, 2'd3);
    cyc();
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    cyc();
    total++; if (bus.cpu_stall !== 1'b0 || addr_err !== 1'b0 || bus.cpu_rdata !== 32'd0 || conflict_cnt !== 32'd0) begin bad++; $display("FAIL rst_mid_read: got stall=%b err=%b rdata=%h cnt=%0d want 0 0 0 0", bus.cpu_stall, addr_err, bus.cpu_rdata, conflict_cnt); end
    rst = 1'b0;
    exp_cnt = 0;
    // IDLE after reset: a fresh load stalls and is issued.
    cyc();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = addr_of(line, 2'd3);
    #1;
    total++; if (bus.cpu_stall !== 1'b1 || bus.mem_en !== 1'b1) begin bad++; $display("FAIL rst_idle: got stall=%b en=%b want 1 1", bus.cpu_stall, bus.mem_en); end
    cyc();
    total++; if (bus.cpu_rdata !== ref_mem[line][127:96]) begin bad++; $display("FAIL rst_reload: got %h want %h", bus.cpu_rdata, ref_mem[line][127:96]); end
    clear_inputs();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_gemm_read();
    test_core_load();
    test_core_store();
    test_back_to_back();
    test_gemm_write();
    test_random_mix();
    test_addr_err();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
